immgen_pipe: RTL and testbench

- Parametrised, pipelined RISC-V immediate generator.
- Decodes every immediate format (I, S, B, U, J, shift-amount) from a 32-bit instruction.
- Sign-extends to XLEN, emits B/J offsets as byte offsets (LSB zero), and flags unsupported opcodes.
- Sits between fetch/decode and execute, behind a valid/ready handshake with a skid buffer so backpressure never drops an instruction.

---
 rtl/immgen_pkg.sv | 29 ++
 rtl/immgen_decode.sv | 75 +++++++
 rtl/immgen_pipe.sv | 102 ++++++++++
 tb/tb_immgen_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// rtl/immgen_pkg.sv - opcode, format and funct3 constants for the immediate generator
package immgen_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRX);
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// rtl/immgen_decode.sv - combinational instruction word to immediate/format/illegal decode
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [31:0] w_raw;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];

    // Every format is first built as a 32-bit value with bit 31 already carrying the sign,
    // so widening to XLEN is a single replication of bit 31.
    always_comb begin
        w_raw     = 32'd0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
                o_fmt = FMT_I;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                if (is_shift_f3(w_f3)) begin
                    o_fmt = FMT_SH;
                    if ((w_opc == OPC_OP_IMM) && (XLEN == 64))
                        w_raw = {26'd0, i_instr[25:20]};
                    else
                        w_raw = {27'd0, i_instr[24:20]};
                end else begin
                    w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
                    o_fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
                o_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_raw = {i_instr[31:12], 12'h000};
                o_fmt = FMT_U;
            end
            OPC_JAL: begin
                w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
                o_fmt = FMT_J;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign o_imm = {{32{w_raw[31]}}, w_raw};
        end else begin : g_x32
            assign o_imm = w_raw;
        end
    endgenerate

endmodule

// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - pipelined immediate generator with output register and skid buffer
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_illegal;
    logic             w_accept;
    logic             w_or_free;

    logic             r_or_valid;
    logic [XLEN-1:0]  r_or_imm;
    logic [2:0]       r_or_fmt;
    logic             r_or_illegal;
    logic [TAG_W-1:0] r_or_tag;

    logic             r_sk_valid;
    logic [XLEN-1:0]  r_sk_imm;
    logic [2:0]       r_sk_fmt;
    logic             r_sk_illegal;
    logic [TAG_W-1:0] r_sk_tag;

    immgen_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    assign in_ready  = !r_sk_valid && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_or_free = !r_or_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or_valid   <= 1'b0;
            r_or_imm     <= '0;
            r_or_fmt     <= FMT_NONE;
            r_or_illegal <= 1'b0;
            r_or_tag     <= '0;
            r_sk_valid   <= 1'b0;
            r_sk_imm     <= '0;
            r_sk_fmt     <= FMT_NONE;
            r_sk_illegal <= 1'b0;
            r_sk_tag     <= '0;
        end else if (w_or_free) begin
            if (r_sk_valid) begin
                // Skid entry is older, so it always drains ahead of new input.
                r_or_valid   <= 1'b1;
                r_or_imm     <= r_sk_imm;
                r_or_fmt     <= r_sk_fmt;
                r_or_illegal <= r_sk_illegal;
                r_or_tag     <= r_sk_tag;
                r_sk_valid   <= w_accept;
                if (w_accept) begin
                    r_sk_imm     <= w_imm;
                    r_sk_fmt     <= w_fmt;
                    r_sk_illegal <= w_illegal;
                    r_sk_tag     <= in_tag;
                end
            end else begin
                r_or_valid <= w_accept;
                if (w_accept) begin
                    r_or_imm     <= w_imm;
                    r_or_fmt     <= w_fmt;
                    r_or_illegal <= w_illegal;
                    r_or_tag     <= in_tag;
                end
            end
        end else if (w_accept) begin
            r_sk_valid   <= 1'b1;
            r_sk_imm     <= w_imm;
            r_sk_fmt     <= w_fmt;
            r_sk_illegal <= w_illegal;
            r_sk_tag     <= in_tag;
        end
    end

    assign out_valid   = r_or_valid;
    assign out_imm     = r_or_imm;
    assign out_fmt     = r_or_fmt;
    assign out_illegal = r_or_illegal;
    assign out_tag     = r_or_tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - table-driven scoreboard bench for immgen_pipe at XLEN 64 and 32
module tb_immgen_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [63:0] tag;
    } exp_t;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm, out_tag;
    logic [2:0]  out_fmt;

    logic        o32_in_ready, o32_valid, o32_illegal;
    logic [31:0] o32_imm;
    logic [63:0] o32_tag;
    logic [2:0]  o32_fmt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    vec_t tbl [NV];
    exp_t sb_q[$];
    exp_t cur_exp;
    exp_t e;

    logic        prev_stall = 1'b0;
    logic [63:0] p_imm, p_tag;
    logic [2:0]  p_fmt;
    logic        p_ill;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(64), .TAG_W(64)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    immgen_pipe #(.XLEN(32), .TAG_W(64)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(o32_valid), .out_ready(out_ready), .out_imm(o32_imm), .out_fmt(o32_fmt),
        .out_illegal(o32_illegal), .out_tag(o32_tag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_imm", out_imm, p_imm);
                chk("hold_fmt", {61'd0, out_fmt}, {61'd0, p_fmt});
                chk("hold_ill", {63'd0, out_illegal}, {63'd0, p_ill});
                chk("hold_tag", out_tag, p_tag);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output actual_tag=%h required=none", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("imm64", out_imm, e.v.imm64);
                    chk("fmt", {61'd0, out_fmt}, {61'd0, e.v.fmt});
                    chk("illegal", {63'd0, out_illegal}, {63'd0, e.v.ill});
                    chk("tag", out_tag, e.tag);
                    chk("valid32", {63'd0, o32_valid}, 64'd1);
                    chk("imm32", {32'd0, o32_imm}, {32'd0, e.v.imm32});
                    chk("fmt32", {61'd0, o32_fmt}, {61'd0, e.v.fmt});
                    chk("illegal32", {63'd0, o32_illegal}, {63'd0, e.v.ill});
                    chk("tag32", o32_tag, e.tag);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
            prev_stall = out_valid && !out_ready;
            p_imm = out_imm;
            p_fmt = out_fmt;
            p_ill = out_illegal;
            p_tag = out_tag;
        end
    end

    task automatic drive(input vec_t v, input logic [63:0] tag, output int waited);
        in_valid = 1'b1;
        in_instr = v.instr;
        in_tag   = tag;
        cur_exp  = '{v: v, tag: tag};
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout actual=stalled required=accepted tag=%h", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  w;
        int  pop0;
        logic done;

        tbl[0]  = '{32'hFF813083, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0};
        tbl[2]  = '{32'h0010006F, 64'h0000000000000800, 32'h00000800, 3'd5, 1'b0};
        tbl[3]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 1'b0};
        tbl[4]  = '{32'h03F09093, 64'd63,               32'd31,       3'd6, 1'b0};
        tbl[5]  = '{32'h0000007F, 64'd0,                32'd0,        3'd0, 1'b1};
        tbl[6]  = '{32'hFE113823, 64'hFFFFFFFFFFFFFFF0, 32'hFFFFFFF0, 3'd2, 1'b0};
        tbl[7]  = '{32'h12345097, 64'h0000000012345000, 32'h12345000, 3'd4, 1'b0};
        tbl[8]  = '{32'h7FF00093, 64'h00000000000007FF, 32'h000007FF, 3'd1, 1'b0};
        tbl[9]  = '{32'h000080E7, 64'd0,                32'd0,        3'd1, 1'b0};
        tbl[10] = '{32'h43F0D09B, 64'd31,               32'd31,       3'd6, 1'b0};
        tbl[11] = '{32'h4210D093, 64'd33,               32'd1,        3'd6, 1'b0};
        tbl[12] = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd5, 1'b0};
        tbl[13] = '{32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0};
        tbl[14] = '{32'h00000033, 64'd0,                32'd0,        3'd0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_tag = 64'd0; out_ready = 1'b0;
        cur_exp = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        chk("rst_out_tag", out_tag, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Full-rate stream: every item must be taken on its first cycle.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i], 64'h1000 + 64'(i), w);
            chk("throughput_wait", 64'(w), 64'd0);
        end
        drain();

        // Same table under random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < NV; i++) drive(tbl[i], 64'h2000 + 64'(i), w);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Backpressure: tags 1..4 with out_ready low for three cycles.
        out_ready = 1'b0;
        pop0 = n_pop;
        fork
            begin
                for (int i = 1; i <= 4; i++) drive(tbl[i-1], 64'(i), w);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
                chk("bp_tag1", out_tag, 64'd1);
                chk("bp_ready_sk_free", {63'd0, in_ready}, 64'd1);
                @(negedge clk);
                chk("bp_ready_sk_full", {63'd0, in_ready}, 64'd0);
                chk("bp_tag1_held", out_tag, 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                chk("bp_ready_still_full", {63'd0, in_ready}, 64'd0);
                @(negedge clk);
                chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
                chk("bp_tag2_out", out_tag, 64'd2);
            end
        join
        drain();
        chk("bp_count", 64'(n_pop - pop0), 64'd4);

        // Reset with both registers occupied.
        out_ready = 1'b0;
        drive(tbl[0], 64'hA0, w);
        drive(tbl[1], 64'hB0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("rstfl_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstfl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstfl_in_ready2", {63'd0, in_ready}, 64'd0);
        chk("rstfl_in_ready32", {63'd0, o32_in_ready}, 64'd0);
        chk("rstfl_out_tag", out_tag, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        pop0 = n_pop;
        drive(tbl[2], 64'hC0, w);
        chk("post_rst_wait", 64'(w), 64'd0);
        @(negedge clk);
        chk("post_rst_latency", {63'd0, out_valid}, 64'd1);
        chk("post_rst_tag", out_tag, 64'hC0);
        drain();
        chk("post_rst_count", 64'(n_pop - pop0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
